// File: rtl/alu_pkg.sv
// Op codes and controller state encoding shared by the ALU-sharing controller,
// its arbiter and the ALU that sits beside it.
package alu_pkg;

  localparam logic [5:0] ALU_OP_ADD = 6'b000000;
  localparam logic [5:0] ALU_OP_SUB = 6'b100010;
  localparam logic [5:0] ALU_OP_MUL = 6'b011000;
  localparam logic [5:0] ALU_OP_AND = 6'b100100;
  localparam logic [5:0] ALU_OP_OR  = 6'b100101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } ctrl_state_e;

  function automatic logic isMulOp(input logic [5:0] op);
    return op == ALU_OP_MUL;
  endfunction

endpackage

// File: rtl/alu32.sv
// Simple combinational ALU instantiated next to alu_share_ctrl; unknown op
// codes produce a zero result.
module alu32
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [5:0]        control_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o
);

  always_comb begin
    result_o = '0;
    case (control_i)
      ALU_OP_ADD: result_o = a_i + b_i;
      ALU_OP_SUB: result_o = a_i - b_i;
      ALU_OP_MUL: result_o = a_i * b_i;
      ALU_OP_AND: result_o = a_i & b_i;
      ALU_OP_OR:  result_o = a_i | b_i;
      default:    result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: grants the only valid requester, or the one
// that did not win last time when both are valid. Purely combinational.
module rr_arb2 (
  input  logic       valid0_i,
  input  logic       valid1_i,
  input  logic       lastGrant_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    if (valid0_i && valid1_i) begin
      grant_o = lastGrant_i ? 2'b01 : 2'b10;
    end else if (valid0_i) begin
      grant_o = 2'b01;
    end else if (valid1_i) begin
      grant_o = 2'b10;
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one external ALU between two requesters: round-robin accept, operands
// held for the op's execute time, then a registered result pulse to the owner.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int MUL_CYCLES = 3,
  parameter int DATA_W     = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Req0_Valid,
  input  logic [5:0]        Req0_Op,
  input  logic [DATA_W-1:0] Req0_A,
  input  logic [DATA_W-1:0] Req0_B,
  output logic              Req0_Ready,
  input  logic              Req1_Valid,
  input  logic [5:0]        Req1_Op,
  input  logic [DATA_W-1:0] Req1_A,
  input  logic [DATA_W-1:0] Req1_B,
  output logic              Req1_Ready,
  output logic              Rsp0_Valid,
  output logic              Rsp1_Valid,
  output logic [DATA_W-1:0] Rsp_Result,
  output logic              Rsp_Zero,
  output logic              Busy,
  output logic [5:0]        ALU_Control,
  output logic [DATA_W-1:0] ALU_A,
  output logic [DATA_W-1:0] ALU_B,
  input  logic [DATA_W-1:0] ALU_Result,
  input  logic              ALU_Zero
);

  localparam int MulEff = (MUL_CYCLES < 1) ? 1 : MUL_CYCLES;
  localparam int CntW   = (MulEff > 1) ? $clog2(MulEff) : 1;
  localparam logic [CntW-1:0] MulLoad = CntW'(MulEff - 1);

  ctrl_state_e       state_q, state_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              lastGrant_q, lastGrant_d;
  logic              owner_q, owner_d;
  logic [5:0]        aluCtrl_q, aluCtrl_d;
  logic [DATA_W-1:0] aluA_q, aluA_d;
  logic [DATA_W-1:0] aluB_q, aluB_d;
  logic [DATA_W-1:0] rspResult_q, rspResult_d;
  logic              rspZero_q, rspZero_d;
  logic              rsp0Valid_q, rsp0Valid_d;
  logic              rsp1Valid_q, rsp1Valid_d;

  logic [1:0]        grant;
  logic              accept0, accept1;
  logic [5:0]        selOp;
  logic [DATA_W-1:0] selA, selB;

  rr_arb2 u_arb (
    .valid0_i    (Req0_Valid),
    .valid1_i    (Req1_Valid),
    .lastGrant_i (lastGrant_q),
    .grant_o     (grant)
  );

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      lastGrant_q <= 1'b1;
      owner_q     <= 1'b0;
      aluCtrl_q   <= '0;
      aluA_q      <= '0;
      aluB_q      <= '0;
      rspResult_q <= '0;
      rspZero_q   <= 1'b0;
      rsp0Valid_q <= 1'b0;
      rsp1Valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      lastGrant_q <= lastGrant_d;
      owner_q     <= owner_d;
      aluCtrl_q   <= aluCtrl_d;
      aluA_q      <= aluA_d;
      aluB_q      <= aluB_d;
      rspResult_q <= rspResult_d;
      rspZero_q   <= rspZero_d;
      rsp0Valid_q <= rsp0Valid_d;
      rsp1Valid_q <= rsp1Valid_d;
    end
  end

  assign accept0 = Req0_Valid && Req0_Ready;
  assign accept1 = Req1_Valid && Req1_Ready;
  assign selOp   = accept1 ? Req1_Op : Req0_Op;
  assign selA    = accept1 ? Req1_A  : Req0_A;
  assign selB    = accept1 ? Req1_B  : Req0_B;

  // The response pulse is registered out of the RESP cycle, so a reset taken
  // in EXEC or RESP drops the transaction before any pulse becomes visible.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    lastGrant_d = lastGrant_q;
    owner_d     = owner_q;
    aluCtrl_d   = aluCtrl_q;
    aluA_d      = aluA_q;
    aluB_d      = aluB_q;
    rspResult_d = rspResult_q;
    rspZero_d   = rspZero_q;
    rsp0Valid_d = (state_q == RESP) && !owner_q;
    rsp1Valid_d = (state_q == RESP) && owner_q;

    case (state_q)
      IDLE, RESP: begin
        if (accept0 || accept1) begin
          state_d     = EXEC;
          aluCtrl_d   = selOp;
          aluA_d      = selA;
          aluB_d      = selB;
          owner_d     = accept1;
          lastGrant_d = accept1;
          count_d     = isMulOp(selOp) ? MulLoad : '0;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        if (count_q != '0) begin
          count_d = count_q - CntW'(1);
        end else begin
          rspResult_d = ALU_Result;
          rspZero_d   = ALU_Zero;
          state_d     = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    Busy       = (state_q == EXEC);
    Req0_Ready = (state_q != EXEC) && grant[0];
    Req1_Ready = (state_q != EXEC) && grant[1];
  end

  assign ALU_Control = aluCtrl_q;
  assign ALU_A       = aluA_q;
  assign ALU_B       = aluB_q;
  assign Rsp_Result  = rspResult_q;
  assign Rsp_Zero    = rspZero_q;
  assign Rsp0_Valid  = rsp0Valid_q;
  assign Rsp1_Valid  = rsp1Valid_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl with the ALU beside it: directed
// scenarios plus random traffic against a transaction-level timing model.
module tb_alu_share_ctrl;
  import alu_pkg::*;

  localparam int MULC = 3;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Req0_Valid, Req1_Valid;
  logic [5:0]  Req0_Op, Req1_Op;
  logic [31:0] Req0_A, Req0_B, Req1_A, Req1_B;
  logic        Req0_Ready, Req1_Ready;
  logic        Rsp0_Valid, Rsp1_Valid;
  logic [31:0] Rsp_Result;
  logic        Rsp_Zero;
  logic        Busy;
  logic [5:0]  ALU_Control;
  logic [31:0] ALU_A, ALU_B, ALU_Result;
  logic        ALU_Zero;

  always #5 Clk = ~Clk;

  alu_share_ctrl #(.MUL_CYCLES(MULC), .DATA_W(32)) dut (
    .Clk(Clk), .Reset(Reset),
    .Req0_Valid(Req0_Valid), .Req0_Op(Req0_Op), .Req0_A(Req0_A), .Req0_B(Req0_B), .Req0_Ready(Req0_Ready),
    .Req1_Valid(Req1_Valid), .Req1_Op(Req1_Op), .Req1_A(Req1_A), .Req1_B(Req1_B), .Req1_Ready(Req1_Ready),
    .Rsp0_Valid(Rsp0_Valid), .Rsp1_Valid(Rsp1_Valid), .Rsp_Result(Rsp_Result), .Rsp_Zero(Rsp_Zero),
    .Busy(Busy), .ALU_Control(ALU_Control), .ALU_A(ALU_A), .ALU_B(ALU_B),
    .ALU_Result(ALU_Result), .ALU_Zero(ALU_Zero)
  );

  alu32 #(.DATA_W(32)) u_alu (
    .control_i(ALU_Control), .a_i(ALU_A), .b_i(ALU_B),
    .result_o(ALU_Result), .zero_o(ALU_Zero)
  );

  typedef struct {
    int          due;
    int          who;
    logic [31:0] res;
    logic        z;
  } rsp_t;

  rsp_t        rspQ[$];
  int          obsLog[$];
  int          errors = 0;
  int          checks = 0;
  int          edges = 0;
  int          freeAt, lastG, busyLo, busyHi;
  logic [5:0]  mCtrl;
  logic [31:0] mA, mB;
  bit          pend[2];
  logic [5:0]  pOp[2];
  logic [31:0] pA[2], pB[2];
  int          raisePct[2];
  bit          addOnly;
  logic [31:0] lastPulseResult;
  logic        lastPulseZero;
  int          lastPulseWho, pulseCount, busyCount;

  function automatic logic [31:0] refAlu(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ALU_OP_ADD: return a + b;
      ALU_OP_SUB: return a - b;
      ALU_OP_MUL: return a * b;
      ALU_OP_AND: return a & b;
      ALU_OP_OR:  return a | b;
      default:    return 32'h0;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic offer(input int n, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    pend[n] = 1'b1;
    pOp[n]  = op;
    pA[n]   = a;
    pB[n]   = b;
  endtask

  task automatic randomOp(input int n);
    logic [5:0]  op;
    logic [31:0] a, b;
    case ($urandom_range(5))
      0: op = ALU_OP_ADD;
      1: op = ALU_OP_SUB;
      2: op = ALU_OP_MUL;
      3: op = ALU_OP_AND;
      4: op = ALU_OP_OR;
      default: op = 6'($urandom);
    endcase
    if (addOnly) op = ALU_OP_ADD;
    a = $urandom;
    b = ($urandom_range(3) == 0) ? a : $urandom;
    offer(n, op, a, b);
  endtask

  task automatic driveInputs();
    Req0_Valid = pend[0]; Req0_Op = pOp[0]; Req0_A = pA[0]; Req0_B = pB[0];
    Req1_Valid = pend[1]; Req1_Op = pOp[1]; Req1_A = pA[1]; Req1_B = pB[1];
  endtask

  // Called at a negedge; checks the outputs left by the last edge, then
  // predicts arbitration for the coming edge from valids and the last winner.
  task automatic applyStimulus(input int nCycles);
    for (int c = 0; c < nCycles; c++) begin
      bit   exp0, exp1, canAcc;
      int   g, e;
      rsp_t r;
      exp0 = 1'b0;
      exp1 = 1'b0;
      if (Busy) busyCount++;
      if (Rsp0_Valid || Rsp1_Valid) begin
        pulseCount++;
        lastPulseResult = Rsp_Result;
        lastPulseZero   = Rsp_Zero;
        lastPulseWho    = Rsp1_Valid ? 1 : 0;
      end
      if (rspQ.size() > 0 && rspQ[0].due == edges) begin
        r = rspQ.pop_front();
        exp0 = (r.who == 0);
        exp1 = (r.who == 1);
        checkOutput("rsp_result", Rsp_Result, r.res);
        checkOutput("rsp_zero", Rsp_Zero, r.z);
      end
      checkOutput("rsp0_valid", Rsp0_Valid, exp0);
      checkOutput("rsp1_valid", Rsp1_Valid, exp1);
      checkOutput("busy", Busy, (edges >= busyLo) && (edges <= busyHi));
      checkOutput("alu_hold", {ALU_Control, ALU_A, ALU_B}, {mCtrl, mA, mB});

      for (int n = 0; n < 2; n++)
        if (!pend[n] && int'($urandom_range(99)) < raisePct[n]) randomOp(n);
      driveInputs();
      #1;
      canAcc = (edges + 1 >= freeAt);
      g = -1;
      if (canAcc) begin
        if (pend[0] && pend[1]) g = 1 - lastG;
        else if (pend[0])       g = 0;
        else if (pend[1])       g = 1;
      end
      checkOutput("req0_ready", Req0_Ready, g == 0);
      checkOutput("req1_ready", Req1_Ready, g == 1);
      if (Req0_Valid && Req0_Ready)      obsLog.push_back(0);
      else if (Req1_Valid && Req1_Ready) obsLog.push_back(1);
      if (g >= 0) begin
        e     = (pOp[g] == ALU_OP_MUL) ? MULC : 1;
        r.due = edges + e + 2;
        r.who = g;
        r.res = refAlu(pOp[g], pA[g], pB[g]);
        r.z   = (r.res == 32'h0);
        rspQ.push_back(r);
        freeAt  = edges + e + 2;
        busyLo  = edges + 1;
        busyHi  = edges + e;
        lastG   = g;
        mCtrl   = pOp[g];
        mA      = pA[g];
        mB      = pB[g];
        pend[g] = 1'b0;
      end
      @(posedge Clk);
      edges++;
      @(negedge Clk);
    end
  endtask

  // Requesters keep their pending ops across reset and reissue afterwards.
  task automatic doReset(input int nEdges);
    Reset = 1'b0;
    Req0_Valid = 1'b0;
    Req1_Valid = 1'b0;
    repeat (nEdges) begin
      @(posedge Clk);
      edges++;
    end
    @(negedge Clk);
    Reset = 1'b1;
    rspQ.delete();
    freeAt = edges + 1;
    lastG  = 1;
    busyLo = 1;
    busyHi = 0;
    mCtrl  = '0;
    mA     = '0;
    mB     = '0;
    checkOutput("rst_busy", Busy, 1'b0);
    checkOutput("rst_alu", {ALU_Control, ALU_A, ALU_B}, 70'h0);
    checkOutput("rst_result", Rsp_Result, 32'h0);
    checkOutput("rst_zero", Rsp_Zero, 1'b0);
    checkOutput("rst_rsp_valid", {Rsp0_Valid, Rsp1_Valid}, 2'b00);
  endtask

  task automatic clearObs();
    pulseCount = 0;
    busyCount = 0;
    lastPulseWho = -1;
    lastPulseResult = 32'hDEAD_BEEF;
    lastPulseZero = 1'bx;
    obsLog.delete();
  endtask

  initial begin
    Reset = 1'b0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    pOp[0] = '0; pOp[1] = '0; pA[0] = '0; pA[1] = '0; pB[0] = '0; pB[1] = '0;
    raisePct[0] = 0; raisePct[1] = 0;
    addOnly = 1'b0;
    driveInputs();
    clearObs();
    @(negedge Clk);
    doReset(3);

    offer(0, ALU_OP_ADD, 32'h0A, 32'h05);
    clearObs();
    applyStimulus(4);
    checkOutput("t1_pulses", pulseCount, 1);
    checkOutput("t1_who", lastPulseWho, 0);
    checkOutput("t1_result", lastPulseResult, 32'h0000000F);
    checkOutput("t1_zero", lastPulseZero, 1'b0);

    offer(1, ALU_OP_SUB, 32'h05, 32'h05);
    clearObs();
    applyStimulus(4);
    checkOutput("t2_pulses", pulseCount, 1);
    checkOutput("t2_who", lastPulseWho, 1);
    checkOutput("t2_result", lastPulseResult, 32'h0);
    checkOutput("t2_zero", lastPulseZero, 1'b1);

    addOnly = 1'b1;
    offer(0, ALU_OP_ADD, 32'h1, 32'h2);
    offer(1, ALU_OP_ADD, 32'h3, 32'h4);
    doReset(1);
    raisePct[0] = 100; raisePct[1] = 100;
    clearObs();
    applyStimulus(9);
    for (int i = 0; i < 4; i++)
      checkOutput("t3_alternate", (i < obsLog.size()) ? obsLog[i] : -1, i % 2);
    raisePct[0] = 0; raisePct[1] = 0;
    applyStimulus(8);

    offer(0, ALU_OP_MUL, 32'h0A, 32'h05);
    clearObs();
    applyStimulus(7);
    checkOutput("t4_busy_cycles", busyCount, MULC);
    checkOutput("t4_pulses", pulseCount, 1);
    checkOutput("t4_who", lastPulseWho, 0);
    checkOutput("t4_result", lastPulseResult, 32'h00000032);

    offer(0, ALU_OP_MUL, 32'h07, 32'h09);
    clearObs();
    applyStimulus(2);
    doReset(1);
    applyStimulus(6);
    checkOutput("t5_no_pulse", pulseCount, 0);
    offer(0, ALU_OP_ADD, 32'h10, 32'h20);
    offer(1, ALU_OP_ADD, 32'h30, 32'h40);
    obsLog.delete();
    applyStimulus(1);
    checkOutput("t5_winner", (obsLog.size() > 0) ? obsLog[0] : -1, 0);
    applyStimulus(8);

    raisePct[0] = 100; raisePct[1] = 0;
    applyStimulus(7);
    offer(1, ALU_OP_ADD, 32'h3, 32'h4);
    obsLog.delete();
    applyStimulus(4);
    checkOutput("t6_req1_first", (obsLog.size() > 0) ? obsLog[0] : -1, 1);
    raisePct[0] = 0;
    applyStimulus(8);

    addOnly = 1'b0;
    for (int blk = 0; blk < 8; blk++) begin
      raisePct[0] = int'($urandom_range(100));
      raisePct[1] = int'($urandom_range(100));
      applyStimulus(50);
      if (blk == 4) doReset(1);
    end
    raisePct[0] = 0; raisePct[1] = 0;
    applyStimulus(20);
    checkOutput("drained", rspQ.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout: got no finish expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
